// File: rtl/bp_cfg_sequencer_if.sv
// Configuration bus between the sequencer (master) and the cores being
// configured (slave): a valid/ready request channel carrying a write or
// read of {core, addr, data}, plus a single-beat readback response channel.
interface bp_cfg_sequencer_if #(
    parameter int cfg_core_width_p = 8,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64
);
    // Request channel, driven by the sequencer.
    logic                        cfg_v_o;
    logic                        cfg_w_o;
    logic [cfg_core_width_p-1:0] cfg_core_o;
    logic [cfg_addr_width_p-1:0] cfg_addr_o;
    logic [cfg_data_width_p-1:0] cfg_data_o;
    // Backpressure and readback response, driven by the configured side.
    logic                        cfg_ready_i;
    logic                        cfg_resp_v_i;
    logic [cfg_data_width_p-1:0] cfg_resp_data_i;

    modport master (
        output cfg_v_o, cfg_w_o, cfg_core_o, cfg_addr_o, cfg_data_o,
        input  cfg_ready_i, cfg_resp_v_i, cfg_resp_data_i
    );

    modport slave (
        input  cfg_v_o, cfg_w_o, cfg_core_o, cfg_addr_o, cfg_data_o,
        output cfg_ready_i, cfg_resp_v_i, cfg_resp_data_i
    );
endinterface

// File: rtl/bp_cfg_sequencer.sv
// Boot-time configuration sequencer. On start_i it walks a per-core table
// held in an external synchronous ROM (one-cycle read latency) and issues
// one config-bus write per entry, core-major order: every entry of core 0,
// then core 1, and so on. done_o is sticky until the next start.
//
// Optional feature: define BP_CFG_SEQ_READBACK_EN to read back every write
// and compare against the written data; a mismatch sets error_o and aborts
// the sequence. In the default build the readback states are unreachable,
// cfg_w_o is 1 whenever cfg_v_o is 1, and error_o is tied low.
module bp_cfg_sequencer #(
    parameter int num_core_p       = 1,
    parameter int num_entries_p    = 16,
    parameter int cfg_core_width_p = 8,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64,
    localparam int entry_width_lp  = $clog2(num_entries_p),
    localparam int rom_width_lp    = cfg_addr_width_p + cfg_data_width_p
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o,
    output logic [entry_width_lp-1:0] rom_addr_o,
    input  logic [rom_width_lp-1:0]   rom_data_i,
    bp_cfg_sequencer_if.master        cfg_bus
);

    // A single-core build still needs a 1-bit counter.
    localparam int core_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FETCH   = 3'd1;
    localparam logic [2:0] ISSUE   = 3'd2;
    localparam logic [2:0] RB_REQ  = 3'd3;
    localparam logic [2:0] RB_WAIT = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]                state_q,     state_d;
    logic [entry_width_lp-1:0] entry_cnt_q, entry_cnt_d;
    logic [core_width_lp-1:0]  core_cnt_q,  core_cnt_d;
    // first_q marks the first ISSUE cycle, when the ROM word is on rom_data_i
    // and has not yet been captured into entry_q.
    logic                      first_q,     first_d;
    logic [rom_width_lp-1:0]   entry_q,     entry_d;
    logic                      done_q,      done_d;

`ifdef BP_CFG_SEQ_READBACK_EN
    logic                      error_q,     error_d;
`endif

    logic [rom_width_lp-1:0]   cur_entry;
    logic                      handshake;
    logic                      last_entry;
    logic                      last_core;
    logic [2:0]                adv_state;
    logic [entry_width_lp-1:0] adv_entry;
    logic [core_width_lp-1:0]  adv_core;

    // The entry being transferred: straight from the ROM in the first ISSUE
    // cycle, from the capture register afterwards, so the payload is stable
    // across any number of stall cycles.
    assign cur_entry  = first_q ? rom_data_i : entry_q;
    assign handshake  = cfg_bus.cfg_v_o & cfg_bus.cfg_ready_i;
    assign last_entry = (entry_cnt_q == entry_width_lp'(num_entries_p - 1));
    assign last_core  = (core_cnt_q == core_width_lp'(num_core_p - 1));

    // Counter advance after an entry is fully finished (write, plus readback
    // when enabled); entry counter wraps naturally since the depth is 2^n.
    always_comb begin
        adv_state = FETCH;
        adv_entry = entry_cnt_q + 1'b1;
        adv_core  = core_cnt_q;
        if (last_entry) begin
            if (last_core) begin
                adv_state = DONE;
            end else begin
                adv_core = core_cnt_q + 1'b1;
            end
        end
    end

    // Next-state logic for the sequencing FSM and its counters.
    always_comb begin
        state_d     = state_q;
        entry_cnt_d = entry_cnt_q;
        core_cnt_d  = core_cnt_q;
        first_d     = 1'b0;
        entry_d     = entry_q;
        done_d      = done_q;
`ifdef BP_CFG_SEQ_READBACK_EN
        error_d     = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = FETCH;
                    entry_cnt_d = '0;
                    core_cnt_d  = '0;
                    done_d      = 1'b0;
`ifdef BP_CFG_SEQ_READBACK_EN
                    error_d     = 1'b0;
`endif
                end
            end
            FETCH: begin
                // rom_addr_o already shows the entry counter; the word comes
                // back during the first ISSUE cycle.
                state_d = ISSUE;
                first_d = 1'b1;
            end
            ISSUE: begin
                if (first_q) begin
                    entry_d = rom_data_i;
                end
                if (handshake) begin
`ifdef BP_CFG_SEQ_READBACK_EN
                    state_d = RB_REQ;
`else
                    state_d     = adv_state;
                    entry_cnt_d = adv_entry;
                    core_cnt_d  = adv_core;
`endif
                end
            end
            RB_REQ: begin
`ifdef BP_CFG_SEQ_READBACK_EN
                if (handshake) begin
                    state_d = RB_WAIT;
                end
`else
                state_d = IDLE;
`endif
            end
            RB_WAIT: begin
`ifdef BP_CFG_SEQ_READBACK_EN
                if (cfg_bus.cfg_resp_v_i) begin
                    if (cfg_bus.cfg_resp_data_i == entry_q[cfg_data_width_p-1:0]) begin
                        state_d     = adv_state;
                        entry_cnt_d = adv_entry;
                        core_cnt_d  = adv_core;
                    end else begin
                        // Mismatch aborts the whole sequence.
                        error_d = 1'b1;
                        state_d = DONE;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // done_o rises together with entry into DONE and stays until start.
        if (state_d == DONE) begin
            done_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            entry_cnt_q <= '0;
            core_cnt_q  <= '0;
            first_q     <= 1'b0;
            entry_q     <= '0;
            done_q      <= 1'b0;
`ifdef BP_CFG_SEQ_READBACK_EN
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            entry_cnt_q <= entry_cnt_d;
            core_cnt_q  <= core_cnt_d;
            first_q     <= first_d;
            entry_q     <= entry_d;
            done_q      <= done_d;
`ifdef BP_CFG_SEQ_READBACK_EN
            error_q     <= error_d;
`endif
        end
    end

    // Config-bus request outputs; the payload is zero whenever no request is
    // being presented, which also covers the reset state.
    always_comb begin
        cfg_bus.cfg_v_o    = 1'b0;
        cfg_bus.cfg_w_o    = 1'b0;
        cfg_bus.cfg_core_o = '0;
        cfg_bus.cfg_addr_o = '0;
        cfg_bus.cfg_data_o = '0;
        if (state_q == ISSUE) begin
            cfg_bus.cfg_v_o    = 1'b1;
            cfg_bus.cfg_w_o    = 1'b1;
            cfg_bus.cfg_core_o = cfg_core_width_p'(core_cnt_q);
            cfg_bus.cfg_addr_o = cur_entry[rom_width_lp-1 -: cfg_addr_width_p];
            cfg_bus.cfg_data_o = cur_entry[cfg_data_width_p-1:0];
        end
`ifdef BP_CFG_SEQ_READBACK_EN
        if (state_q == RB_REQ) begin
            cfg_bus.cfg_v_o    = 1'b1;
            cfg_bus.cfg_w_o    = 1'b0;
            cfg_bus.cfg_core_o = cfg_core_width_p'(core_cnt_q);
            cfg_bus.cfg_addr_o = entry_q[rom_width_lp-1 -: cfg_addr_width_p];
        end
`endif
    end

    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign rom_addr_o = entry_cnt_q;

`ifdef BP_CFG_SEQ_READBACK_EN
    assign error_o = error_q;
`else
    assign error_o = 1'b0;
    // The response channel only matters when readback is built in.
    logic unused_resp;
    assign unused_resp = ^{cfg_bus.cfg_resp_v_i, cfg_bus.cfg_resp_data_i};
`endif

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
// Bench for bp_cfg_sequencer (2 cores x 4 entries). Stimulus pushes the
// expected writes into a queue; a negedge monitor pops and compares each
// completed write. Build with BP_CFG_SEQ_READBACK_EN to exercise readback.
module tb_bp_cfg_sequencer;
    localparam int NC = 2;
    localparam int NE = 4;
    localparam int CW = 8;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int XW = CW + AW + DW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, error;
    logic [1:0] rom_addr;
    logic [AW+DW-1:0] rom_data;
    logic [AW+DW-1:0] rom [NE];

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int stall_cnt = 0;
    bit ignore_stall = 1'b0;
    logic [XW-1:0] exp_q [$];

    bp_cfg_sequencer_if #(.cfg_core_width_p(CW), .cfg_addr_width_p(AW),
                          .cfg_data_width_p(DW)) bus ();

    bp_cfg_sequencer #(
        .num_core_p(NC), .num_entries_p(NE), .cfg_core_width_p(CW),
        .cfg_addr_width_p(AW), .cfg_data_width_p(DW)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start),
        .busy_o(busy), .done_o(done), .error_o(error),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data), .cfg_bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        rom[0] = {16'h0010, 64'h0123_4567_89AB_CDEF};
        rom[1] = {16'h0024, 64'hDEAD_BEEF_0000_0001};
        rom[2] = {16'h0038, 64'hCAFE_F00D_1234_5678};
        rom[3] = {16'h004C, 64'hFFFF_0000_FFFF_0000};
    end

    // Synchronous ROM, one-cycle latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_seq();
        for (int c = 0; c < NC; c++) begin
            for (int e = 0; e < NE; e++) begin
                exp_q.push_back({CW'(c), rom[e]});
            end
        end
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Counts cycles from cycle 1 (start was high in cycle 0) until done_o.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (1) begin
            @(negedge clk);
            if (done || cyc >= 400) break;
            cyc++;
        end
    endtask

    // Monitor / scoreboard.
    logic [XW-1:0] cur;
    logic [XW-1:0] stall_x;
    bit prev_stall = 1'b0;
    logic [CW-1:0] last_wr_core;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;
    always @(negedge clk) begin
        cur = {bus.cfg_core_o, bus.cfg_addr_o, bus.cfg_data_o};
        if (reset_n) begin
            if (prev_stall && !ignore_stall) begin
                check("stall_hold_v", bus.cfg_v_o, 1'b1);
                check("stall_hold_payload", cur, stall_x);
            end
            prev_stall = 1'b0;
            if (bus.cfg_v_o) begin
`ifndef BP_CFG_SEQ_READBACK_EN
                check("cfg_w_on_v", bus.cfg_w_o, 1'b1);
`endif
                if (!bus.cfg_ready_i) begin
                    prev_stall = 1'b1;
                    stall_x = cur;
                    stall_cnt++;
                end else if (bus.cfg_w_o) begin
                    wr_cnt++;
                    check("write_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) check("write_xfer", cur, exp_q.pop_front());
                    last_wr_core = bus.cfg_core_o;
                    last_wr_addr = bus.cfg_addr_o;
                    last_wr_data = bus.cfg_data_o;
                end else begin
                    rd_cnt++;
                    check("read_req", cur, {last_wr_core, last_wr_addr, {DW{1'b0}}});
                end
            end
        end
    end

`ifdef BP_CFG_SEQ_READBACK_EN
    // Responder: answers each read one cycle later, optionally corrupting
    // the response for core 0 entry 2.
    bit corrupt = 1'b0;
    bit rsp_pend = 1'b0;
    logic [DW-1:0] rsp_val;
    logic [AW+DW-1:0] rom2;
    always @(negedge clk) begin
        rom2 = rom[2];
        if (bus.cfg_v_o && bus.cfg_ready_i && !bus.cfg_w_o) begin
            rsp_pend = 1'b1;
            rsp_val = last_wr_data ^ DW'(corrupt && last_wr_core == 0 &&
                                         last_wr_addr == rom2[AW+DW-1:DW]);
        end
    end
    always @(posedge clk) begin
        #1;
        bus.cfg_resp_v_i = rsp_pend;
        bus.cfg_resp_data_i = rsp_pend ? rsp_val : '0;
        rsp_pend = 1'b0;
    end
`else
    // Response channel must be ignored: toggle it randomly.
    always @(posedge clk) begin
        #1;
        bus.cfg_resp_v_i = 1'($urandom);
        bus.cfg_resp_data_i = {$urandom, $urandom};
    end
`endif

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int cyc;
        int w0;
        int s0;
        int vcnt;
        logic [AW+DW-1:0] r;
        bus.cfg_ready_i = 1'b1;
        bus.cfg_resp_v_i = 1'b0;
        bus.cfg_resp_data_i = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_cfg_v", bus.cfg_v_o, 1'b0);
        check("rst_rom_addr", rom_addr, 2'd0);
        check("rst_payload", {bus.cfg_core_o, bus.cfg_addr_o, bus.cfg_data_o}, '0);

`ifndef BP_CFG_SEQ_READBACK_EN
        // Back-to-back writes with ready held high.
        push_seq(); w0 = wr_cnt;
        start_pulse();
        wait_done(cyc);
        $display("run basic: done at cycle %0d, writes %0d", cyc, wr_cnt - w0);
        check("basic_done_cycle", cyc, 17);
        check("basic_busy_in_done", busy, 1'b1);
        check("basic_writes", wr_cnt - w0, 8);
        check("basic_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        check("basic_idle_busy", busy, 1'b0);
        check("basic_done_sticky", done, 1'b1);
        check("basic_error", error, 1'b0);

        // Extra start pulse mid-sequence is ignored.
        push_seq(); w0 = wr_cnt;
        start_pulse();
        fork
            wait_done(cyc);
            begin
                repeat (3) @(posedge clk); #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        join
        $display("run restart-ignored: done at cycle %0d, writes %0d", cyc, wr_cnt - w0);
        check("restart_done_cycle", cyc, 17);
        check("restart_writes", wr_cnt - w0, 8);

        // Ready low for 5 cycles while entry 2 of core 0 is presented.
        push_seq(); w0 = wr_cnt; s0 = stall_cnt;
        start_pulse();
        fork
            wait_done(cyc);
            begin
                repeat (5) @(posedge clk); #1 bus.cfg_ready_i = 1'b0;
                repeat (5) @(posedge clk); #1 bus.cfg_ready_i = 1'b1;
            end
        join
        $display("run stall: done at cycle %0d, writes %0d, stalls %0d", cyc, wr_cnt - w0, stall_cnt - s0);
        check("stall_done_cycle", cyc, 22);
        check("stall_writes", wr_cnt - w0, 8);
        check("stall_cycles", stall_cnt - s0, 5);

        // Reset while core 1 entry 1 is presented (handshake held off).
        push_seq(); w0 = wr_cnt;
        start_pulse();
        ignore_stall = 1'b1;
        repeat (11) @(posedge clk);
        #1 bus.cfg_ready_i = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        r = rom[1];
        check("rst_mid_pre_v", bus.cfg_v_o, 1'b1);
        check("rst_mid_pre_core", bus.cfg_core_o, 8'd1);
        check("rst_mid_pre_addr", bus.cfg_addr_o, r[AW+DW-1:DW]);
        @(posedge clk); #1 reset_n = 1'b1; bus.cfg_ready_i = 1'b1;
        @(negedge clk);
        $display("run reset-mid: writes %0d before reset", wr_cnt - w0);
        check("rst_mid_cfg_v", bus.cfg_v_o, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_writes", wr_cnt - w0, 5);
        exp_q.delete();
        ignore_stall = 1'b0;

        // Fresh start after reset begins again at core 0 entry 0.
        push_seq(); w0 = wr_cnt;
        start_pulse();
        wait_done(cyc);
        $display("run after-reset: done at cycle %0d, writes %0d", cyc, wr_cnt - w0);
        check("after_rst_done_cycle", cyc, 17);
        check("after_rst_writes", wr_cnt - w0, 8);
        check("after_rst_error", error, 1'b0);
`else
        // Readback with all responses matching.
        corrupt = 1'b0;
        push_seq(); w0 = wr_cnt; s0 = rd_cnt;
        start_pulse();
        wait_done(cyc);
        $display("run readback-ok: done at cycle %0d, writes %0d, reads %0d", cyc, wr_cnt - w0, rd_cnt - s0);
        check("rb_ok_done", done, 1'b1);
        check("rb_ok_error", error, 1'b0);
        check("rb_ok_writes", wr_cnt - w0, 8);
        check("rb_ok_reads", rd_cnt - s0, 8);

        // Readback mismatch on core 0 entry 2 aborts the sequence.
        corrupt = 1'b1;
        push_seq(); w0 = wr_cnt; s0 = rd_cnt;
        start_pulse();
        wait_done(cyc);
        $display("run readback-bad: done at cycle %0d, writes %0d, reads %0d", cyc, wr_cnt - w0, rd_cnt - s0);
        check("rb_bad_done", done, 1'b1);
        check("rb_bad_error", error, 1'b1);
        check("rb_bad_writes", wr_cnt - w0, 3);
        check("rb_bad_reads", rd_cnt - s0, 3);
        exp_q.delete();
        vcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.cfg_v_o) vcnt++;
        end
        check("rb_bad_no_more_v", vcnt, 0);
        check("rb_bad_error_sticky", error, 1'b1);
        corrupt = 1'b0;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
